// File: rtl/freq_meter_if.sv
// Result channel of freq_meter: measurement fields plus valid/ready handshake.
// meas_period exists only when FREQ_METER_PERIOD_EN is defined.
interface freq_meter_if #(
  parameter int CNT_W = 26
);
  logic [CNT_W-1:0] meas_count;
  logic             meas_sat;
  logic             meas_overrun;
  logic             meas_valid;
  logic             meas_ready;
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] meas_period;

  modport master (output meas_count, meas_sat, meas_overrun, meas_valid, meas_period,
                  input  meas_ready);
  modport slave  (input  meas_count, meas_sat, meas_overrun, meas_valid, meas_period,
                  output meas_ready);
`else
  modport master (output meas_count, meas_sat, meas_overrun, meas_valid,
                  input  meas_ready);
  modport slave  (input  meas_count, meas_sat, meas_overrun, meas_valid,
                  output meas_ready);
`endif
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clk_in cycles.
// Optional macro FREQ_METER_PERIOD_EN adds the last rise-to-rise interval (meas_period).
//
// state | meaning
// IDLE  | counters held at zero, waiting for enable
// GATE  | gate window running, rises being counted
module freq_meter #(
  parameter int GATE_CYCLES = 20000000,
  parameter int CNT_W       = 26
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         sig_in,
  input  logic         enable,
  freq_meter_if.master meas
);
  // Gate counter is widened only when CNT_W cannot reach the terminal value.
  localparam int GATE_W = ($clog2(GATE_CYCLES) > CNT_W) ? $clog2(GATE_CYCLES) : CNT_W;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, GATE} state_t;

  state_t            state, state_nx;
  logic              sync1, sync2, sync3;
  logic              rise;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_sum;
  logic              sat_flag;
  logic              sat_hit;
  logic              term;
  logic              abort;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise     = sync2 & ~sync3;
  assign sat_hit  = rise & (edge_cnt == CNT_MAX);
  assign edge_sum = (edge_cnt == CNT_MAX) ? CNT_MAX : (rise ? edge_cnt + CNT_ONE : edge_cnt);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    term     = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: if (enable) state_nx = GATE;
      GATE: begin
        if (gate_cnt == GATE_LAST) begin
          term = 1'b1;
          if (!enable) state_nx = IDLE;
        end else if (!enable) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else if (state != GATE || term || abort) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat_flag <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_ONE;
      edge_cnt <= edge_sum;
      sat_flag <= sat_flag | sat_hit;
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] last_period;
  logic [CNT_W-1:0] gap;
  logic             seen_one;
  logic             seen_two;

  // gap is the interval that a rise on this cycle would close
  assign gap = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_ONE;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt  <= '0;
      last_period <= '0;
      seen_one    <= 1'b0;
      seen_two    <= 1'b0;
    end else if (state != GATE || term || abort) begin
      period_cnt  <= '0;
      last_period <= '0;
      seen_one    <= 1'b0;
      seen_two    <= 1'b0;
    end else if (rise) begin
      period_cnt <= '0;
      if (seen_one) last_period <= gap;
      seen_two   <= seen_one;
      seen_one   <= 1'b1;
    end else begin
      period_cnt <= gap;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meas.meas_count   <= '0;
      meas.meas_sat     <= 1'b0;
      meas.meas_overrun <= 1'b0;
      meas.meas_valid   <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
      meas.meas_period  <= '0;
`endif
    end else if (term) begin
      meas.meas_count   <= edge_sum;
      meas.meas_sat     <= sat_flag | sat_hit;
      meas.meas_overrun <= meas.meas_valid & ~meas.meas_ready;
      meas.meas_valid   <= 1'b1;
`ifdef FREQ_METER_PERIOD_EN
      if (rise) meas.meas_period <= seen_one ? gap : '0;
      else      meas.meas_period <= seen_two ? last_period : '0;
`endif
    end else if (meas.meas_valid && meas.meas_ready) begin
      meas.meas_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter (GATE_CYCLES=100) with CNT_W=8 and a CNT_W=5 saturation copy.
module tb_freq_meter;
  typedef struct {
    int count;
    int sat;
    int ovr;
    int period;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sig_in;
  logic enable;
  logic en5;
  logic ready;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q5[$];
  exp_t e;
  exp_t e5;

  freq_meter_if #(.CNT_W(8)) mif ();
  freq_meter_if #(.CNT_W(5)) mif5 ();

  assign mif.meas_ready  = ready;
  assign mif5.meas_ready = 1'b1;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut (
    .clk_in(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable), .meas(mif.master));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(5)) dut5 (
    .clk_in(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(en5), .meas(mif5.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input int s, input int o, input int p, input int cy);
    exp_t r;
    r.count = c; r.sat = s; r.ovr = o; r.period = p; r.cyc = cy;
    return r;
  endfunction

  // sig_in waveform at t cycles after the window-start drive point
  function automatic logic sig_val(input int mode, input int a, input int t);
    case (mode)
      1:       return (t % 10) < 5;
      2:       return (t % 2) == 0;
      3:       return (t < 100) ? ((t % 10) < 5) : ((t < 192) ? (((t - 100) % 8) < 4) : 1'b0);
      4:       return (t >= a) && (t <= a + 3);
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && mif.meas_valid && mif.meas_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got count %0d at cycle %0d, expected no result",
                 mif.meas_count, cyc);
      end else begin
        e = q.pop_front();
        chk("count", int'(mif.meas_count), e.count);
        chk("sat", int'(mif.meas_sat), e.sat);
        chk("overrun", int'(mif.meas_overrun), e.ovr);
        chk("result_cycle", cyc, e.cyc);
`ifdef FREQ_METER_PERIOD_EN
        chk("period", int'(mif.meas_period), e.period);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mif5.meas_valid && mif5.meas_ready) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result5: got count %0d at cycle %0d, expected no result",
                 mif5.meas_count, cyc);
      end else begin
        e5 = q5.pop_front();
        chk("count5", int'(mif5.meas_count), e5.count);
        chk("sat5", int'(mif5.meas_sat), e5.sat);
        chk("result_cycle5", cyc, e5.cyc);
`ifdef FREQ_METER_PERIOD_EN
        chk("period5", int'(mif5.meas_period), e5.period);
`endif
      end
    end
  end

  // Runs n back-to-back windows from idle; enable drops so it is sampled on the last terminal cycle.
  task automatic run_windows(input int mode, input int a, input int n, input bit use5,
                             input int c0, input int c1, input int c2,
                             input int p0, input int p1, input int p2);
    int t0;
    int cs[3];
    int ps[3];
    cs[0] = c0; cs[1] = c1; cs[2] = c2;
    ps[0] = p0; ps[1] = p1; ps[2] = p2;
    @(posedge clk); #1;
    t0 = cyc;
    sig_in = sig_val(mode, a, 0);
    enable = 1'b1;
    en5    = use5;
    for (int k = 1; k <= n; k++) begin
      q.push_back(mk(cs[k-1], 0, 0, ps[k-1], t0 + 1 + 100 * k));
      if (use5) q5.push_back(mk(31, 1, 0, 2, t0 + 1 + 100 * k));
    end
    for (int t = 1; t <= 100 * n; t++) begin
      @(posedge clk); #1;
      sig_in = sig_val(mode, a, t);
      if (t == 100 * n) begin
        enable = 1'b0;
        en5    = 1'b0;
      end
    end
    sig_in = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; sig_in = 1'b0; enable = 1'b0; en5 = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_valid", int'(mif.meas_valid), 0);
    chk("reset_count", int'(mif.meas_count), 0);
    chk("reset_sat", int'(mif.meas_sat), 0);
    chk("reset_overrun", int'(mif.meas_overrun), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_windows(1, 0, 3, 1'b0, 10, 10, 10, 10, 10, 10);
    run_windows(0, 0, 2, 1'b0, 0, 0, 0, 0, 0, 0);
    run_windows(2, 0, 2, 1'b1, 50, 50, 0, 2, 2, 0);
    run_windows(4, 98, 2, 1'b0, 1, 0, 0, 0, 0, 0);
    run_windows(4, 99, 2, 1'b0, 0, 1, 0, 0, 0, 0);

    // Two windows unaccepted: second result overwrites the first
    ready = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    sig_in = sig_val(3, 0, 0);
    enable = 1'b1;
    q.push_back(mk(12, 0, 1, 8, t0 + 205));
    for (int t = 1; t <= 205; t++) begin
      @(posedge clk); #1;
      sig_in = sig_val(3, 0, t);
      if (t == 200) enable = 1'b0;
      if (t == 203) chk("overrun_valid_held", int'(mif.meas_valid), 1);
      if (t == 205) ready = 1'b1;
    end
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("valid_cleared_after_accept", int'(mif.meas_valid), 0);
    ready = 1'b1;
    repeat (3) @(posedge clk);

    // Abort at gate_cnt=50, then a full window after re-enable
    @(posedge clk); #1;
    sig_in = sig_val(1, 0, 0);
    enable = 1'b1;
    for (int t = 1; t <= 250; t++) begin
      @(posedge clk); #1;
      sig_in = sig_val(1, 0, t);
      if (t == 51) enable = 1'b0;
    end
    sig_in = 1'b0;
    repeat (5) @(posedge clk);
    run_windows(1, 0, 1, 1'b0, 10, 0, 0, 10, 0, 0);

    // Async reset with a pending result
    ready = 1'b0;
    @(posedge clk); #1;
    sig_in = sig_val(1, 0, 0);
    enable = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      @(posedge clk); #1;
      sig_in = sig_val(1, 0, t);
    end
    chk("pre_reset_valid", int'(mif.meas_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", int'(mif.meas_valid), 0);
    chk("async_reset_count", int'(mif.meas_count), 0);
    chk("async_reset_overrun", int'(mif.meas_overrun), 0);
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    rst_n  = 1'b1;
    sig_in = sig_val(1, 0, 0);
    q.push_back(mk(10, 0, 0, 10, t0 + 101));
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk); #1;
      sig_in = sig_val(1, 0, t);
      if (t == 100) enable = 1'b0;
    end
    sig_in = 1'b0;
    repeat (6) @(posedge clk);

    chk("queue_drain", q.size(), 0);
    chk("queue5_drain", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
